// File: rtl/xoodoo_perm_sched_if.sv
// xoodoo_perm_sched_if: requester handshake and shared round-datapath signals of the permutation scheduler
interface xoodoo_perm_sched_if #(parameter int NREQ = 3);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic [NREQ*384-1:0] req_state;
  logic [383:0] state_out;
  logic [383:0] rnd_state;
  logic [383:0] rnd_result;
  logic [31:0] rnd_const;
  logic busy;
  modport master (
    output req, req_state, rnd_result,
    input gnt, done, state_out, busy, rnd_state, rnd_const
  );
  modport slave (
    input req, req_state, rnd_result,
    output gnt, done, state_out, busy, rnd_state, rnd_const
  );
endinterface

// File: rtl/xoodoo_perm_sched.sv
// xoodoo_perm_sched: round-robin scheduler sharing one combinational Xoodoo round among NREQ requesters
module xoodoo_perm_sched #(
  parameter int NREQ = 3,
  parameter int NROUNDS = 12
) (
  input logic eph1,
  input logic reset,
  xoodoo_perm_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [11:0] RC [12] = '{12'h058, 12'h038, 12'h3C0, 12'h0D0, 12'h120, 12'h014,
                                      12'h060, 12'h02C, 12'h380, 12'h0F0, 12'h1A0, 12'h012};
  localparam logic [3:0] RC_OFS = 4'(12 - NROUNDS);
  localparam logic [3:0] LAST = 4'(NROUNDS - 1);
  state_t state, nxt;
  logic [383:0] st_reg, load_state;
  logic [3:0] rnd_cnt;
  logic [NREQ-1:0] rr_ptr, gnt, win, sh;
  logic [2:0] ptr_idx, idx;
  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < NREQ; i++) ptr_idx = rr_ptr[i] ? 3'(i) : ptr_idx;
  end
  // scan from the pointer downwards so the nearest requester at/after rr_ptr overwrites the rest
  always_comb begin
    win = '0;
    idx = '0;
    sh = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (ptr_idx + 3'(k) >= 3'(NREQ)) ? ptr_idx + 3'(k) - 3'(NREQ) : ptr_idx + 3'(k);
      sh = bus.req >> idx;
      win = sh[0] ? NREQ'(1) << idx : win;
    end
  end
  always_comb begin
    load_state = '0;
    for (int i = 0; i < NREQ; i++) load_state = win[i] ? bus.req_state[384*i +: 384] : load_state;
  end
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (|bus.req ? RUN : IDLE) :
          state == RUN  ? (rnd_cnt == LAST ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge eph1) state <= reset ? IDLE : nxt;
  always_ff @(posedge eph1) begin
    if (reset) begin
      st_reg <= '0;
      rnd_cnt <= '0;
      gnt <= '0;
      rr_ptr <= NREQ'(1);
    end else if (state == IDLE && |bus.req) begin
      st_reg <= load_state;
      gnt <= win;
      rnd_cnt <= '0;
    end else if (state == RUN) begin
      st_reg <= bus.rnd_result;
      rnd_cnt <= rnd_cnt == LAST ? rnd_cnt : rnd_cnt + 4'd1;
    end else if (state == DONE) begin
      gnt <= '0;
      rr_ptr <= {gnt[NREQ-2:0], gnt[NREQ-1]};
    end
  end
  assign bus.gnt = gnt;
  assign bus.done = state == DONE ? gnt : '0;
  assign bus.busy = state != IDLE;
  assign bus.state_out = st_reg;
  assign bus.rnd_state = st_reg;
  assign bus.rnd_const = state == RUN ? {20'h0, RC[rnd_cnt + RC_OFS]} : 32'h0;
endmodule

// File: doc/xoodoo_perm_sched.md
# xoodoo_perm_sched

Scheduler that shares one combinational single-round Xoodoo datapath (`xooround`-style round logic) among several requesters: absorb, encrypt and squeeze. It arbitrates requests round-robin and loads the winner's 384-bit state. It iterates the round datapath for the configured number of rounds, supplying the round constant each cycle, and returns the permuted state with a one-cycle done pulse to the granted requester.

## Interface
- `NREQ`, default 3: number of requesters (2–4).
- `NROUNDS`, default 12: rounds per permutation (1–12). Uses the last `NROUNDS` entries of the constant table.

Ports:
- `eph1` — in — 1 — clock; all state updates on its rising edge.
- `reset` — in — 1 — synchronous, active-high reset.
- `req` — in — `NREQ` — per-requester permutation request, level.
- `req_state` — in — `NREQ*384` — requester i state at `[384*i +: 384]`.
- `gnt` — out — `NREQ` — one-hot grant, registered, high from load until done.
- `done` — out — `NREQ` — one-hot, one-cycle pulse; `state_out` valid in that cycle.
- `state_out` — out — 384 — permuted state of the last completed permutation.
- `busy` — out — 1 — high in RUN and DONE.
- `rnd_state` — out — 384 — to round datapath input; equals internal state register.
- `rnd_const` — out — 32 — round constant for the current round.
- `rnd_result` — in — 384 — round datapath output (combinational in `rnd_state`, `rnd_const`).

## Operation
- Constant table, round order: 0x058, 0x038, 0x3C0, 0x0D0, 0x120, 0x014, 0x060, 0x02C, 0x380, 0x0F0, 0x1A0, 0x012.
- `rnd_const = RC[rnd_cnt + 12 - NROUNDS]`, zero-extended to 32 bits. It is 0 outside RUN.
- 4-bit `rnd_cnt` and `NREQ`-bit round-robin pointer `rr_ptr` (one-hot, priority start).
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when any `req` is high:
  - Winner g is the first set `req` bit at or above `rr_ptr`, wrapping.
  - Load `st_reg <= req_state[g]`, `gnt <= onehot(g)`, `rnd_cnt <= 0`.
- IDLE with no request: hold; all outputs stable.
- RUN, every cycle: `st_reg <= rnd_result`, `rnd_cnt <= rnd_cnt + 1`.
- RUN → DONE when `rnd_cnt == NROUNDS-1`; the final `rnd_result` is captured on that edge.
- DONE, one cycle:
  - `done[g] = 1`; `state_out = st_reg`.
  - On exit: `gnt <= 0`, `rr_ptr <= rotate-left(onehot(g))`, go to IDLE.
- `state_out` is driven from `st_reg`. It is only meaningful during the `done` pulse and is held until the next load.
- Requester rules:
  - Hold `req` and `req_state` stable until the load edge.
  - Drop `req` in or after the `done` cycle, or it is re-arbitrated as a new request in the next IDLE cycle.
- `req` deasserted during RUN: ignored; the permutation completes and `done` still pulses.
- `req` of other requesters during RUN/DONE: not sampled until IDLE. No request is lost while it is held.
- Domain/padding XORs (0x01, 0x40, 0x80) are the requesters' job, applied to `req_state` before requesting.

## Timing
- Reset values:
  - FSM=IDLE, `gnt=0`, `done=0`, `busy=0`.
  - `st_reg=0` (so `state_out=0`, `rnd_state=0`).
  - `rnd_cnt=0`, `rnd_const=0`, `rr_ptr=onehot(0)`.
- Reset asserted mid-RUN or in DONE: next edge returns to IDLE with reset values. No `done` pulse is produced.
- Latency: `req` sampled in IDLE at edge 0, RUN for `NROUNDS` cycles, `done` high in cycle `NROUNDS+1`. Default: 13 cycles after the sampling edge.
- Throughput: one permutation per `NROUNDS+2` cycles (14 default) under continuous requests.
- Simultaneous requests in IDLE: exactly one grant per the pointer. Others wait; each pending requester is served within `NREQ` permutations.
- `rnd_cnt` never exceeds `NROUNDS-1`; there is no wrap.

## Test plan
Bench round stub: `rnd_result = rnd_state ^ {352'h0, rnd_const}`.
- Single request: `req=001`, `req_state[0]=0`.
  - `gnt=001` for 13 cycles.
  - `rnd_const` sequence 0x058…0x012.
  - `done=001` in cycle 13; `state_out[31:0]=0x0CA`, upper bits 0.
- Simultaneous `req=111` held after reset: grants in order 0, 1, 2, 0. Each permutation is 14 cycles apart; `done` is one-hot and matches `gnt`.
- `req[0]` dropped in RUN cycle 3: `done[0]` still pulses at cycle 13 with the correct `state_out`. There is no second grant to 0 unless it re-asserts.
- Reset asserted in RUN cycle 6:
  - Next cycle shows all reset values.
  - No `done` pulse.
  - A fresh `req=010` runs normally.
- `NROUNDS=6`, input 0: constants 0x060, 0x02C, 0x380, 0x0F0, 0x1A0, 0x012. `done` arrives in cycle 7 with `state_out[31:0]=0x28E`.
- `req=100` idle→run with `req=011` arriving during RUN: after done(2), `rr_ptr` wraps to 0, so requester 0 is granted next, then 1.
